// File: rtl/addsub_rr_scheduler.sv
// Round-robin shared add/subtract unit: NUM_REQ requesters, one op in flight.
// Define ADDSUB_SCHED_FLAGS_EN to add the registered carry/borrow output rsp_carry_o.
module addsub_rr_scheduler #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]            req_sub_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic [ID_W-1:0]               rsp_id_o,
`ifdef ADDSUB_SCHED_FLAGS_EN
  output logic                          rsp_carry_o,
`endif
  output logic                          busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       last_grant_q, id_q, rsp_id_q, grant;
  logic [DATA_WIDTH-1:0] a_q, b_q, rsp_data_q;
  logic                  sub_q, rsp_valid_q, found, hs;
  int                    idx;

  // Search starts one past the last winner so it has lowest priority.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(last_grant_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  assign hs = (state_q == IDLE) && found;

  always_comb begin
    req_ready_o = '0;
    if (hs) req_ready_o[grant] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef ADDSUB_SCHED_FLAGS_EN
  logic [DATA_WIDTH:0] res_w;
  logic                rsp_carry_q;
  // Bit DATA_WIDTH is the carry-out for add and the borrow for subtract.
  assign res_w = sub_q ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
  assign rsp_carry_o = rsp_carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rsp_carry_q <= 1'b0;
    else if (state_q == EXEC) rsp_carry_q <= res_w[DATA_WIDTH];
  end
`else
  logic [DATA_WIDTH-1:0] res_w;
  assign res_w = sub_q ? (a_q - b_q) : (a_q + b_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        a_q          <= req_a_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        b_q          <= req_b_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        sub_q        <= req_sub_i[grant];
        id_q         <= grant;
        last_grant_q <= grant;
      end
      if (state_q == EXEC) begin
        rsp_data_q  <= res_w[DATA_WIDTH-1:0];
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
      end
      if (state_q == RESP && rsp_ready_i) rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Scoreboard bench for addsub_rr_scheduler: per-requester op queues, grant-order and result checks.
module tb_addsub_rr_scheduler;
  localparam int NR = 4;
  localparam int DW = 8;

  typedef struct packed {logic [7:0] a; logic [7:0] b; logic sub;} op_t;
  typedef struct packed {logic [1:0] id; logic [7:0] data; logic carry;} exp_t;

  logic             clk, rst_n;
  logic [NR-1:0]    req_valid, req_ready, req_sub, hs;
  logic [NR*DW-1:0] req_a, req_b;
  logic             rsp_valid, rsp_ready, busy;
  logic [DW-1:0]    rsp_data;
  logic [1:0]       rsp_id;
  logic             rsp_carry;

  op_t  rq[NR][$];
  exp_t sb[$];
  int   gq[$];
  int   total, bad;

  addsub_rr_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_sub_i(req_sub),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_id_o(rsp_id),
`ifdef ADDSUB_SCHED_FLAGS_EN
    .rsp_carry_o(rsp_carry),
`endif
    .busy_o(busy)
  );

`ifndef ADDSUB_SCHED_FLAGS_EN
  assign rsp_carry = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int id, input op_t op);
    logic [8:0] w;
    exp_t e;
    w = op.sub ? ({1'b0, op.a} - {1'b0, op.b}) : ({1'b0, op.a} + {1'b0, op.b});
    e.id    = id[1:0];
    e.data  = w[7:0];
    e.carry = w[8];
    return e;
  endfunction

  task automatic push_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic sub);
    op_t op;
    op.a = a; op.b = b; op.sub = sub;
    rq[i].push_back(op);
  endtask

  // Requester driver: present queue heads, retire on handshake.
  initial begin
    req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; hs = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) hs[i] = rst_n & req_valid[i] & req_ready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (hs[i] && rq[i].size() > 0) begin
          sb.push_back(model(i, rq[i][0]));
          if (gq.size() > 0) chk("grant_order", i, gq.pop_front());
          void'(rq[i].pop_front());
        end
        if (rq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_a[i*DW +: DW]  = rq[i][0].a;
          req_b[i*DW +: DW]  = rq[i][0].b;
          req_sub[i]         = rq[i][0].sub;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("rdy_onehot", ($countones(req_ready) <= 1), 1);
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) chk("sb_spurious", sb.size(), 1);
          else begin
            e = sb.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_id", rsp_id, e.id);
`ifdef ADDSUB_SCHED_FLAGS_EN
            chk("rsp_carry", rsp_carry, e.carry);
`endif
          end
        end
      end
    end
  end

  task automatic wait_idle(input int max);
    logic done;
    int   q;
    done = 1'b0;
    for (int c = 0; c < max && !done; c++) begin
      @(negedge clk);
      q = 0;
      for (int i = 0; i < NR; i++) q += rq[i].size();
      done = (q == 0) && (sb.size() == 0) && !busy && (req_valid == '0);
    end
    chk("idle_timeout", done, 1);
  endtask

  task automatic wait_rsp(input int max);
    for (int c = 0; c < max && !rsp_valid; c++) @(negedge clk);
    chk("rsp_timeout", rsp_valid, 1);
  endtask

  initial begin
    int seen;
    total = 0; bad = 0;
    rst_n = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", req_ready, 0);
    chk("rst_carry", rsp_carry, 0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Single add, latency check
    push_op(0, 8'h10, 8'h05, 1'b0); gq.push_back(0);
    @(posedge clk); #2;
    @(negedge clk); chk("t1_ready", req_ready, 4'b0001);
    @(negedge clk); chk("t1_exec_vld", rsp_valid, 0); chk("t1_busy", busy, 1);
    @(negedge clk); chk("t1_vld", rsp_valid, 1); chk("t1_data", rsp_data, 8'h15); chk("t1_id", rsp_id, 0);
    wait_idle(50);

    // Subtract wrap
    push_op(1, 8'h03, 8'h05, 1'b1); gq.push_back(1);
    wait_rsp(20);
    chk("t2_data", rsp_data, 8'hFE); chk("t2_id", rsp_id, 1);
`ifdef ADDSUB_SCHED_FLAGS_EN
    chk("t2_borrow", rsp_carry, 1);
`endif
    wait_idle(50);

    // Add overflow
    push_op(3, 8'hFF, 8'h02, 1'b0); gq.push_back(3);
    wait_rsp(20);
    chk("t3_data", rsp_data, 8'h01); chk("t3_id", rsp_id, 3);
`ifdef ADDSUB_SCHED_FLAGS_EN
    chk("t3_carry", rsp_carry, 1);
`endif
    wait_idle(50);

    // Fairness: all four valid, requester 0 comes back for a second op
    push_op(0, 8'h11, 8'h22, 1'b0); push_op(0, 8'h80, 8'h80, 1'b0);
    push_op(1, 8'h50, 8'h60, 1'b1); push_op(2, 8'h7F, 8'h01, 1'b0);
    push_op(3, 8'h00, 8'h01, 1'b1);
    gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3); gq.push_back(0);
    wait_idle(100);

    // Backpressure
    rsp_ready = 1'b0;
    push_op(2, 8'h20, 8'h01, 1'b1); gq.push_back(2);
    wait_rsp(20);
    push_op(3, 8'h0A, 8'h0B, 1'b0); gq.push_back(3);
    repeat (5) begin
      @(negedge clk);
      chk("bp_vld", rsp_valid, 1); chk("bp_data", rsp_data, 8'h1F);
      chk("bp_id", rsp_id, 2); chk("bp_rdy", req_ready, 0);
    end
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); chk("bp_done_vld", rsp_valid, 0); chk("bp_done_busy", busy, 0);
    wait_idle(50);

    // Reset during EXEC
    push_op(1, 8'h40, 8'h01, 1'b0); gq.push_back(1);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(posedge clk); #2;
      seen = sb.size();
    end
    chk("t6_accept", seen, 1);
    chk("t6_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", rsp_valid, 0); chk("t6_rst_busy", busy, 0);
    sb.delete(); gq.delete();
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    push_op(2, 8'h33, 8'h11, 1'b1); push_op(0, 8'h01, 8'h01, 1'b0);
    gq.push_back(0); gq.push_back(2);
    wait_idle(50);

    // Random traffic
    for (int k = 0; k < 24; k++)
      push_op($urandom_range(0, NR-1), 8'($urandom), 8'($urandom), 1'($urandom));
    wait_idle(600);
    chk("sb_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
